// File: rtl/apb_pkg.sv
// Shared APB slave definitions: bus widths and FSM state encoding.
// Imported by apb_slave and apb_slave_regfile.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t IDLE   = 2'd0;
    localparam apb_state_t SETUP  = 2'd1;
    localparam apb_state_t ACCESS = 2'd2;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x 8 register storage: one synchronous write port,
// one combinational read port, asynchronous clear.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                  pclk,
    input  logic                  prstn,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [APB_DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [APB_DATA_W-1:0] o_rdata
);

    logic [APB_DATA_W-1:0] r_mem [DEPTH];

    // Clear all entries on reset, otherwise write one entry when enabled
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave.sv
// APB slave with an 8-bit register file and address-error response.
// Optional wait states are enabled with macro APB_SLAVE_WAIT_EN.
module apb_slave
    import apb_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  pclk,
    input  logic                  prstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [APB_ADDR_W:0] DEPTH_W = (APB_ADDR_W + 1)'(DEPTH);

    apb_state_t            r_state;
    logic [AW-1:0]         r_addr;
    logic                  r_write;
    logic [APB_DATA_W-1:0] r_wdata;
    logic                  r_err;
    logic [APB_DATA_W-1:0] r_rdata;

    logic                  w_pready;
    logic                  w_err_now;
    logic                  w_we;
    logic [APB_DATA_W-1:0] w_rd;

    assign w_err_now = ({1'b0, paddr} >= DEPTH_W);

`ifdef APB_SLAVE_WAIT_EN
    logic [7:0] r_wait;

    // Wait counter: load on entry to ACCESS, count down while selected
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_wait <= '0;
        end else if (r_state == SETUP) begin
            r_wait <= 8'(WAIT_CYCLES);
        end else if (r_state == ACCESS && r_wait != 8'd0
                     && psel && penable) begin
            r_wait <= r_wait - 8'd1;
        end else begin
            r_wait <= '0;
        end
    end

    assign w_pready = (r_state == ACCESS) && (r_wait == 8'd0);
`else
    logic w_unused_wait;

    assign w_unused_wait = ^WAIT_CYCLES;
    assign w_pready      = (r_state == ACCESS);
`endif

    assign w_we = w_pready & r_write & ~r_err;

    // Bus phase tracking; completion takes priority over abort
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (psel && !penable) r_state <= SETUP;
                end
                SETUP: begin
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (w_pready) begin
                        r_state <= (psel && !penable) ? SETUP : IDLE;
                    end else if (!psel || !penable) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Capture the request and preload read data as ACCESS begins
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (r_state == SETUP) begin
            r_addr  <= paddr[AW-1:0];
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_err   <= w_err_now;
            if (!pwrite) begin
                r_rdata <= w_err_now ? '0 : w_rd;
            end
        end
    end

    apb_slave_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .pclk    (pclk),
        .prstn   (prstn),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_raddr (paddr[AW-1:0]),
        .o_rdata (w_rd)
    );

    assign prdata  = r_rdata;
    assign pready  = w_pready;
    assign pslverr = w_pready & r_err;

endmodule

// File: tb/tb_apb_slave.sv
// Self-checking bench for apb_slave: vector table, chained and
// idle-robustness sequences, random traffic against a register model.
module tb_apb_slave;
    import apb_pkg::*;

    localparam int DEPTH = 16;
    localparam int WAITC = 2;
`ifdef APB_SLAVE_WAIT_EN
    localparam int EXP_ACC = WAITC + 1;
`else
    localparam int EXP_ACC = 1;
`endif

    logic       pclk = 1'b0;
    logic       prstn;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdl [DEPTH];
    logic [7:0] last_rd;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t tbl [10];

    always #5 pclk = ~pclk;

    apb_slave #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .pclk    (pclk),
        .prstn   (prstn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
        last_rd = 8'h00;
    endtask

    // Present a setup phase, then raise penable for the access phase
    task automatic setup_phase(input logic wr, input logic [7:0] a,
                               input logic [7:0] d);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        @(posedge pclk);
        #1;
        penable = 1'b1;
    endtask

    task automatic wait_ready(output int n, output logic [7:0] rd,
                              output logic er);
        n  = -1;
        rd = 8'h00;
        er = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge pclk);
            @(negedge pclk);
            if (pready) begin
                n  = i;
                rd = prdata;
                er = pslverr;
                break;
            end
        end
    endtask

    task automatic op(input logic wr, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] exp_rd,
                      input logic exp_err, input string tag);
        int         n;
        logic [7:0] rd;
        logic       er;
        setup_phase(wr, a, d);
        wait_ready(n, rd, er);
        chk({tag, ".latency"}, n, EXP_ACC);
        chk({tag, ".prdata"}, {24'h0, rd}, {24'h0, exp_rd});
        chk({tag, ".pslverr"}, {31'h0, er}, {31'h0, exp_err});
    endtask

    // Transfer with expectations taken from the register model
    task automatic mop(input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input string tag);
        logic       ee;
        logic [7:0] er;
        ee = (int'(a) >= DEPTH);
        er = wr ? last_rd : (ee ? 8'h00 : mdl[a[3:0]]);
        op(wr, a, d, er, ee, tag);
        if (wr && !ee) mdl[a[3:0]] = d;
        if (!wr) last_rd = er;
    endtask

    task automatic end_xfer();
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       wr;
        logic [7:0] a;

        tbl[0] = '{1'b1, 8'h00, 8'h01, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 8'h00, 8'h01, 1'b0};
        tbl[2] = '{1'b1, 8'h20, 8'hAA, 8'h01, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 8'h00, 8'h01, 1'b0};
        tbl[4] = '{1'b0, 8'h20, 8'h00, 8'h00, 1'b1};
        tbl[5] = '{1'b1, 8'h0F, 8'h5A, 8'h00, 1'b0};
        tbl[6] = '{1'b0, 8'h0F, 8'h00, 8'h5A, 1'b0};
        tbl[7] = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1};
        tbl[8] = '{1'b1, 8'hFF, 8'h11, 8'h00, 1'b1};
        tbl[9] = '{1'b0, 8'h0F, 8'h00, 8'h5A, 1'b0};

        prstn   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        model_clear();
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("reset.prdata", {24'h0, prdata}, 32'h0);
        chk("reset.pready", {31'h0, pready}, 32'h0);
        chk("reset.pslverr", {31'h0, pslverr}, 32'h0);
        prstn = 1'b1;

        // Vector table; first transfer starts on the first edge out of reset
        for (int i = 0; i < 10; i++) begin
            op(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp_rd,
               tbl[i].exp_err, $sformatf("tbl%0d", i));
            end_xfer();
            if (tbl[i].wr && int'(tbl[i].addr) < DEPTH)
                mdl[tbl[i].addr[3:0]] = tbl[i].data;
            if (!tbl[i].wr) last_rd = tbl[i].exp_rd;
        end

        // Back-to-back chain with no idle cycle between transfers
        mop(1'b1, 8'h01, 8'h02, "b2b0");
        mop(1'b1, 8'h02, 8'h03, "b2b1");
        mop(1'b0, 8'h01, 8'h00, "b2b2");
        mop(1'b0, 8'h02, 8'h00, "b2b3");
        mop(1'b1, 8'h07, 8'h3C, "b2b4");
        mop(1'b0, 8'h07, 8'h00, "b2b5");
        end_xfer();

        // penable without a proper setup phase must be ignored in IDLE
        psel    = 1'b0;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 8'h03;
        pwdata  = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            chk("idle_pen.pready", {31'h0, pready}, 32'h0);
        end
        psel = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            chk("idle_selpen.pready", {31'h0, pready}, 32'h0);
        end
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk);
        #1;
        mop(1'b0, 8'h03, 8'h00, "idle_rd");
        end_xfer();

        // Random traffic, sometimes chained, some illegal addresses
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                a = 8'($urandom_range(DEPTH, 255));
            else
                a = 8'($urandom_range(0, DEPTH - 1));
            mop(wr, a, 8'($urandom), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) end_xfer();
        end
        end_xfer();

`ifdef APB_SLAVE_WAIT_EN
        // Wait-state write, then an abort while waiting
        mop(1'b1, 8'h05, 8'h77, "wait_wr");
        end_xfer();
        mop(1'b0, 8'h05, 8'h00, "wait_rd");
        end_xfer();
        setup_phase(1'b1, 8'h06, 8'h99);
        @(posedge pclk);
        @(negedge pclk);
        chk("abort.pready_wait", {31'h0, pready}, 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk);
            @(negedge pclk);
            chk("abort.pready", {31'h0, pready}, 32'h0);
            chk("abort.pslverr", {31'h0, pslverr}, 32'h0);
        end
        @(posedge pclk);
        #1;
        mop(1'b0, 8'h06, 8'h00, "abort_rd");
        end_xfer();
`endif

        // Reset pulsed during the ACCESS phase of a write
        mop(1'b1, 8'h0E, 8'hA5, "pre_rst_wr");
        end_xfer();
        mop(1'b0, 8'h0E, 8'h00, "pre_rst_rd");
        end_xfer();
        setup_phase(1'b1, 8'h04, 8'h55);
        @(posedge pclk);
        #2;
        prstn = 1'b0;
        #1;
        chk("midrst.prdata", {24'h0, prdata}, 32'h0);
        chk("midrst.pready", {31'h0, pready}, 32'h0);
        chk("midrst.pslverr", {31'h0, pslverr}, 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        model_clear();
        @(negedge pclk);
        @(negedge pclk);
        prstn = 1'b1;
        mop(1'b0, 8'h04, 8'h00, "post_rst_rd04");
        end_xfer();
        mop(1'b0, 8'h0E, 8'h00, "post_rst_rd0E");
        end_xfer();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 Parameter DEPTH, 16, number of 8-bit registers; legal addresses are 0..DEPTH-1.
REQ-002 Parameter WAIT_CYCLES, 2, wait states per access; used only when APB_SLAVE_WAIT_EN is defined.
REQ-003 pclk  input  1  sole clock; all state changes on rising edge.
REQ-004 prstn  input  1  reset, asynchronous assert, active-low.
REQ-005 psel  input  1  slave select from master.
REQ-006 penable  input  1  access phase indicator.
REQ-007 pwrite  input  1  1=write, 0=read.
REQ-008 paddr  input  8  byte address.
REQ-009 pwdata  input  8  write data.
REQ-010 prdata  output  8  read data.
REQ-011 pready  output  1  transfer completes this cycle when high in ACCESS.
REQ-012 pslverr  output  1  error response, valid only while pready=1.

Function
REQ-013 FSM states IDLE, SETUP, ACCESS:
- IDLE->SETUP on psel=1 and penable=0.
- SETUP->ACCESS unconditionally on the next edge.
- ACCESS->IDLE on pready=1 when psel=0 at completion.
- ACCESS->SETUP on pready=1 when psel=1 and penable=0 (back-to-back).
REQ-014 SETUP capture: paddr, pwrite and pwdata are latched at the SETUP->ACCESS edge; later bus changes during ACCESS are ignored.
REQ-015 Error flag: the address-error flag is computed at SETUP from paddr >= DEPTH.
REQ-016 pready is 1 only in ACCESS with the wait counter at zero; 0 in IDLE and SETUP.
REQ-017 Write commit: the latched data is written to the register file on the pready=1 edge in ACCESS when the latched pwrite=1 and the address is legal; exactly one write per transfer.
REQ-018 Read data: prdata is loaded from the register file at the SETUP->ACCESS edge for legal reads, loaded with 8'h00 for illegal reads, and held otherwise (including across writes).
REQ-019 pslverr equals the latched address-error flag while pready=1, else 0; an illegal write leaves all registers unchanged.
REQ-020 Abort: if psel or penable deasserts in ACCESS before pready, the slave returns to IDLE, commits no write and asserts no pslverr.
REQ-021 IDLE robustness: penable=1 with psel=0, or penable=1 in IDLE, is ignored and the FSM stays IDLE.
REQ-022 Write-then-read: a read of an address in the transfer immediately following a write to that address returns the new data.

Reset
REQ-023 On prstn=0, immediately and independent of pclk: state=IDLE, wait counter=0, prdata=8'h00, pready=0, pslverr=0, all registers=8'h00.
REQ-024 Reset asserted mid-transfer cancels the transfer with no write committed.
REQ-025 The first transfer is accepted on the first pclk edge with prstn=1.

Configuration
REQ-026 With macro APB_SLAVE_WAIT_EN defined: the wait counter loads WAIT_CYCLES on entry to ACCESS and decrements per cycle, so pready rises after WAIT_CYCLES cycles in ACCESS.
REQ-027 With APB_SLAVE_WAIT_EN undefined: the counter is absent, pready=1 in the first ACCESS cycle, and every transfer is two cycles.

Structure
REQ-028 Package apb_pkg holds the FSM state typedef (IDLE/SETUP/ACCESS) and constants APB_ADDR_W=8 and APB_DATA_W=8.
REQ-029 Sub-module apb_slave_regfile holds the DEPTH x 8 storage:
- one synchronous write port;
- one combinational read port;
- asynchronous clear on prstn.

Verification
REQ-030 Write 8'h01 to 8'h00, then read 8'h00 (wait disabled): pready high in cycle 2 of each transfer, prdata=8'h01, pslverr=0.
REQ-031 Back-to-back writes 8'h02@8'h01 and 8'h03@8'h02 with no IDLE, then reads: both values returned with no dropped transfer.
REQ-032 Write 8'hAA to 8'h20 (>= DEPTH): pslverr=1 with pready, and a subsequent read of 8'h00 is unchanged; a read of 8'h20 gives prdata=8'h00 with pslverr=1.
REQ-033 APB_SLAVE_WAIT_EN with WAIT_CYCLES=2: a write to 8'h05 completes with pready on the 3rd ACCESS cycle and the register updates exactly once.
REQ-034 prstn pulsed low mid-ACCESS of a write 8'h55@8'h04: outputs return to zero immediately, and a read of 8'h04 after reset gives 8'h00.
REQ-035 psel dropped in ACCESS during a wait (wait enabled): FSM returns to IDLE, no write occurs and pslverr stays 0.
